// File: rtl/sccb_pkg.sv
// Shared constants for the SCCB write arbiter: FSM state encodings, engine
// acknowledge codes, the OV7670 write address and an index-width helper.
package sccb_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StAddr  = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StFin   = 3'd4;
    localparam logic [2:0] StGap   = 3'd5;

    // eng_ack[1] is the 9th-bit tick, eng_ack[0] the sampled ACK.
    localparam logic [1:0] ACK_OK   = 2'b11;
    localparam logic [1:0] ACK_NACK = 2'b10;

    localparam logic [7:0] OV7670_WR_ADDR = 8'h42;

    // Width of an index into n items (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sccb_arbiter_if.sv
// Bundle of requester-side and byte-engine-side signals of the SCCB arbiter.
//   master : arbiter view (drives req_ready/done/err/busy and engine strobes)
//   slave  : environment view (requesters + i2c_top engine)
interface sccb_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              busy;
    logic              eng_start;
    logic              eng_stop;
    logic [7:0]        eng_wr_data;
    logic [1:0]        eng_ack;
    logic [3:0]        eng_state;

    modport master (
        input  req_valid, req_addr, req_data, eng_ack, eng_state,
        output req_ready, done, err, busy, eng_start, eng_stop, eng_wr_data
    );

    modport slave (
        output req_valid, req_addr, req_data, eng_ack, eng_state,
        input  req_ready, done, err, busy, eng_start, eng_stop, eng_wr_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the lowest requesting index strictly
// after last_i, wrapping around.
//   req_i   : request vector
//   last_i  : index granted last time
//   gnt_o   : one-hot grant (zero when no request)
//   idx_o   : index of the grant
//   valid_o : any request present
module rr_arbiter
    import sccb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        // Offset k = 1 is the first candidate after last_i, k = NREQ is last_i itself.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && req_i[j] && (j == (32'(last_i) + k) % NREQ)) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IW'(j);
                end
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/sccb_arbiter.sv
// Shares one SCCB byte engine between NREQ requesters posting single-register
// writes. Sequences device address, register address, data and stop, then
// holds an idle gap before reporting done/err to the owning requester.
//   clk, rst_n : system clock, asynchronous active-low reset (shared with engine)
//   bus        : sccb_arbiter_if.master (requester handshake + engine strobes)
// Optional build macro SCCB_ARB_RETRY_EN: retry a NACKed write up to MAX_RETRY
// more times before raising err.
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter logic [7:0]  DEV_ADDR   = OV7670_WR_ADDR,
    parameter int unsigned GAP_CYCLES = 65536,
    parameter int unsigned MAX_RETRY  = 3
) (
    input logic            clk,
    input logic            rst_n,
    sccb_arbiter_if.master bus
);

    localparam int unsigned IW = idx_width(NREQ);

    if (NREQ < 1 || NREQ > 8 || GAP_CYCLES < 1 || MAX_RETRY > 255) begin : g_param_err
        $error("sccb_arbiter: parameter out of range");
    end

    logic [2:0]      state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            fail_q, fail_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            any_req;
    logic [7:0]      sel_addr, sel_data;
    logic            gap_exit;

    logic [NREQ-1:0] ready_c, done_c, err_c;
    logic            start_c, stop_c;
    logic [7:0]      wr_c;

`ifdef SCCB_ARB_RETRY_EN
    localparam int unsigned AW = idx_width(MAX_RETRY + 1);
    logic [AW-1:0] attempt_q, attempt_d;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (any_req)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_addr = bus.req_addr[8*i +: 8];
                sel_data = bus.req_data[8*i +: 8];
            end
        end
    end

    assign gap_exit = (cnt_q >= GAP_CYCLES - 1) && (bus.eng_state == 4'd0);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fail_d  = fail_q;
        cnt_d   = '0;
`ifdef SCCB_ARB_RETRY_EN
        attempt_d = attempt_q;
`endif
        ready_c = '0;
        done_c  = '0;
        err_c   = '0;
        start_c = 1'b0;
        stop_c  = 1'b0;
        wr_c    = '0;

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    ready_c = arb_gnt;
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_idx;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    fail_d  = 1'b0;
`ifdef SCCB_ARB_RETRY_EN
                    attempt_d = '0;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                start_c = 1'b1;
                wr_c    = DEV_ADDR;
                state_d = StAddr;
            end
            StAddr: begin
                if (bus.eng_ack == ACK_OK) begin
                    wr_c    = addr_q;
                    state_d = StData;
                end else if (bus.eng_ack == ACK_NACK) begin
                    stop_c  = 1'b1;
                    fail_d  = 1'b1;
                    state_d = StGap;
                end
            end
            StData: begin
                if (bus.eng_ack == ACK_OK) begin
                    wr_c    = data_q;
                    state_d = StFin;
                end else if (bus.eng_ack == ACK_NACK) begin
                    stop_c  = 1'b1;
                    fail_d  = 1'b1;
                    state_d = StGap;
                end
            end
            StFin: begin
                if (bus.eng_ack[1]) begin
                    stop_c  = 1'b1;
                    fail_d  = ~bus.eng_ack[0];
                    state_d = StGap;
                end
            end
            StGap: begin
                // Saturate so a long engine-busy wait cannot wrap the counter.
                cnt_d = (cnt_q >= GAP_CYCLES - 1) ? cnt_q : cnt_q + 32'd1;
                if (gap_exit) begin
                    cnt_d   = '0;
                    last_d  = gidx_q;
                    state_d = StIdle;
                    if (fail_q) err_c = gnt_q;
                    else        done_c = gnt_q;
`ifdef SCCB_ARB_RETRY_EN
                    // Retry keeps ownership: no report, no re-arbitration.
                    if (fail_q && (32'(attempt_q) < MAX_RETRY)) begin
                        err_c     = '0;
                        last_d    = last_q;
                        fail_d    = 1'b0;
                        attempt_d = attempt_q + 1'b1;
                        state_d   = StStart;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= IW'(NREQ - 1);
            gidx_q  <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            fail_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SCCB_ARB_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) attempt_q <= '0;
        else        attempt_q <= attempt_d;
    end
`endif

    // req_ready is decoded from IDLE, which is also the reset state, so it must
    // be masked while reset is held to keep all outputs quiet.
    assign bus.req_ready   = ready_c & {NREQ{rst_n}};
    assign bus.done        = done_c;
    assign bus.err         = err_c;
    assign bus.busy        = (state_q != StIdle);
    assign bus.eng_start   = start_c;
    assign bus.eng_stop    = stop_c;
    assign bus.eng_wr_data = wr_c;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter with a small behavioural byte-engine model.
module tb_sccb_arbiter;

    localparam int unsigned GAP  = 16;
    localparam int          STOP = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sccb_arbiter_if #(.NREQ(2)) bus ();

    sccb_arbiter #(
        .NREQ       (2),
        .DEV_ADDR   (8'h42),
        .GAP_CYCLES (GAP),
        .MAX_RETRY  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Engine model controls and observation logs.
    int m_cnt, m_tick, m_hold, m_hold_left, m_nack_byte, m_nack_attempts, m_attempt;
    bit m_active, nack;
    int bytes_q[$], start_cyc[$], stop_cyc[$], acc_idx[$], acc_cyc[$];
    int done_idx[$], done_cyc[$], err_idx[$], err_cyc[$];
    int busy_viol;

    function automatic int oh_idx(input logic [1:0] v);
        return (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : -1;
    endfunction

    // Engine: acks each byte 3 cycles after it is offered, optionally NACKs a chosen
    // byte for the first m_nack_attempts attempts (-1 = always), then stays busy
    // m_hold cycles after a stop.
    initial begin
        m_active = 0; m_cnt = 0; m_tick = 0; m_hold = 0; m_hold_left = 0;
        m_nack_byte = -1; m_nack_attempts = 0; m_attempt = 0; busy_viol = 0;
        bus.eng_ack = 2'b00;
        bus.eng_state = 4'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_active && m_cnt == 0) begin
                nack = (m_tick == m_nack_byte) &&
                       (m_nack_attempts < 0 || m_attempt < m_nack_attempts);
                bus.eng_ack = {1'b1, ~nack};
            end else begin
                bus.eng_ack = 2'b00;
            end
            bus.eng_state = (m_active || m_hold_left > 0) ? 4'd1 : 4'd0;
            #1;
            if (!rst_n) begin
                m_active = 0;
                m_hold_left = 0;
            end else begin
                if (bus.req_ready != 0) begin
                    acc_idx.push_back(oh_idx(bus.req_ready));
                    acc_cyc.push_back(cyc);
                    if (bus.busy) busy_viol++;
                end
                if (bus.done != 0) begin
                    done_idx.push_back(oh_idx(bus.done));
                    done_cyc.push_back(cyc);
                end
                if (bus.err != 0) begin
                    err_idx.push_back(oh_idx(bus.err));
                    err_cyc.push_back(cyc);
                end
                if (bus.eng_start) begin
                    bytes_q.push_back(int'(bus.eng_wr_data));
                    start_cyc.push_back(cyc);
                    m_active = 1; m_cnt = 2; m_tick = 0;
                end else if (m_active) begin
                    if (m_cnt == 0) begin
                        if (bus.eng_stop) begin
                            bytes_q.push_back(STOP);
                            stop_cyc.push_back(cyc);
                            m_active = 0;
                            m_hold_left = m_hold;
                            m_attempt++;
                        end else begin
                            bytes_q.push_back(int'(bus.eng_wr_data));
                            m_tick++;
                            m_cnt = 2;
                        end
                    end else begin
                        m_cnt--;
                    end
                end else if (m_hold_left > 0) begin
                    m_hold_left--;
                end
            end
        end
    end

    task automatic clear_logs();
        bytes_q.delete(); start_cyc.delete(); stop_cyc.delete();
        acc_idx.delete(); acc_cyc.delete(); done_idx.delete(); done_cyc.delete();
        err_idx.delete(); err_cyc.delete();
        busy_viol = 0;
        m_attempt = 0;
    endtask

    // Raise one request, hold it until accepted, then drop it and scramble operands.
    task automatic post_one(input int who, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.req_addr[8*who +: 8] = a;
        bus.req_data[8*who +: 8] = d;
        bus.req_valid[who] = 1'b1;
        #2;
        for (int i = 0; i < 20 && acc_idx.size() == 0; i++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.req_addr = '1;
        bus.req_data = '1;
    endtask

    task automatic wait_txn(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #2;
            if (done_idx.size() + err_idx.size() >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        @(negedge clk);
        #2;
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        total++; if (bus.done !== 2'b00) begin bad++; $display("FAIL reset_done: got %b want 00", bus.done); end
        total++; if (bus.err !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", bus.err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.eng_start !== 1'b0) begin bad++; $display("FAIL reset_eng_start: got %b want 0", bus.eng_start); end
        total++; if (bus.eng_stop !== 1'b0) begin bad++; $display("FAIL reset_eng_stop: got %b want 0", bus.eng_stop); end
        total++; if (bus.eng_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data: got %h want 00", bus.eng_wr_data); end
        bus.req_valid = 2'b11;
        #1;
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready_masked: got %b want 00", bus.req_ready); end
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int exp_b[$];
        bit ok, mism;
        clear_logs();
        m_hold = 0; m_nack_byte = -1;
        post_one(0, 8'h12, 8'h80);
        wait_txn(1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout: got %0d events want 1", done_idx.size() + err_idx.size()); end
        total++; if (acc_idx.size() != 1 || acc_idx[0] != 0) begin bad++; $display("FAIL single_grant: got %p want '{0}", acc_idx); end
        total++;
        if ((start_cyc.size() > 0 && acc_cyc.size() > 0 ? start_cyc[0] - acc_cyc[0] : -1) !== 1) begin
            bad++; $display("FAIL single_start_lat: got start %p accept %p want 1 cycle apart", start_cyc, acc_cyc);
        end
        exp_b = {32'h42, 32'h12, 32'h80, STOP};
        mism = (bytes_q.size() != exp_b.size());
        if (!mism) for (int i = 0; i < exp_b.size(); i++) if (bytes_q[i] != exp_b[i]) mism = 1;
        total++; if (mism) begin bad++; $display("FAIL single_bytes: got %p want %p", bytes_q, exp_b); end
        total++; if (done_idx.size() != 1 || done_idx[0] != 0 || err_idx.size() != 0) begin
            bad++; $display("FAIL single_done: done %p err %p want done '{0} no err", done_idx, err_idx);
        end
        total++;
        if ((done_cyc.size() > 0 && stop_cyc.size() > 0 ? done_cyc[0] - stop_cyc[0] : -1) !== int'(GAP)) begin
            bad++; $display("FAIL single_gap: got done %p stop %p want %0d apart", done_cyc, stop_cyc, GAP);
        end
        @(negedge clk);
        #2;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        int exp_b[$], exp_g[$];
        bit ok, mism;
        clear_logs();
        @(negedge clk);
        bus.req_addr = {8'h20, 8'h10};
        bus.req_data = {8'h02, 8'h01};
        bus.req_valid = 2'b11;
        wait_txn(4, ok);
        bus.req_valid = '0;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rr_timeout: got %0d events want 4", done_idx.size()); end
        // Requester 0 owned the previous write, so requester 1 goes first.
        exp_g = {1, 0, 1, 0};
        mism = (acc_idx.size() != exp_g.size());
        if (!mism) for (int i = 0; i < exp_g.size(); i++) if (acc_idx[i] != exp_g[i]) mism = 1;
        total++; if (mism) begin bad++; $display("FAIL rr_grants: got %p want %p", acc_idx, exp_g); end
        total++; if (busy_viol !== 0) begin bad++; $display("FAIL rr_ready_while_busy: got %0d want 0", busy_viol); end
        exp_b = {32'h42, 32'h20, 32'h02, STOP, 32'h42, 32'h10, 32'h01, STOP};
        mism = (bytes_q.size() < exp_b.size());
        if (!mism) for (int i = 0; i < exp_b.size(); i++) if (bytes_q[i] != exp_b[i]) mism = 1;
        total++; if (mism) begin bad++; $display("FAIL rr_bytes: got %p want prefix %p", bytes_q, exp_b); end
        total++; if (done_idx.size() != 4 || done_idx[0] != 1 || done_idx[1] != 0) begin
            bad++; $display("FAIL rr_done: got %p want '{1,0,1,0}", done_idx);
        end
        @(negedge clk);
    endtask

`ifndef SCCB_ARB_RETRY_EN
    task automatic test_nack();
        int exp_b[$];
        bit ok, mism;
        clear_logs();
        m_nack_byte = 1; m_nack_attempts = -1;
        post_one(0, 8'h33, 8'h44);
        wait_txn(1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL nack_timeout: got %0d events want 1", err_idx.size()); end
        exp_b = {32'h42, 32'h33, STOP};
        mism = (bytes_q.size() != exp_b.size());
        if (!mism) for (int i = 0; i < exp_b.size(); i++) if (bytes_q[i] != exp_b[i]) mism = 1;
        total++; if (mism) begin bad++; $display("FAIL nack_bytes: got %p want %p", bytes_q, exp_b); end
        total++; if (err_idx.size() != 1 || err_idx[0] != 0 || done_idx.size() != 0) begin
            bad++; $display("FAIL nack_err: err %p done %p want err '{0} no done", err_idx, done_idx);
        end
        total++;
        if ((err_cyc.size() > 0 && stop_cyc.size() > 0 ? err_cyc[0] - stop_cyc[0] : -1) !== int'(GAP)) begin
            bad++; $display("FAIL nack_gap: got err %p stop %p want %0d apart", err_cyc, stop_cyc, GAP);
        end
        total++; if (start_cyc.size() !== 1) begin bad++; $display("FAIL nack_starts: got %0d want 1", start_cyc.size()); end
        m_nack_byte = -1; m_nack_attempts = 0;
    endtask
`else
    task automatic test_retry();
        int exp_b[$];
        bit ok, mism;
        clear_logs();
        m_nack_byte = 1; m_nack_attempts = 2;
        post_one(0, 8'h33, 8'h44);
        wait_txn(1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL retry_timeout: got %0d events want 1", done_idx.size()); end
        exp_b = {32'h42, 32'h33, STOP, 32'h42, 32'h33, STOP, 32'h42, 32'h33, 32'h44, STOP};
        mism = (bytes_q.size() != exp_b.size());
        if (!mism) for (int i = 0; i < exp_b.size(); i++) if (bytes_q[i] != exp_b[i]) mism = 1;
        total++; if (mism) begin bad++; $display("FAIL retry_bytes: got %p want %p", bytes_q, exp_b); end
        total++; if (done_idx.size() != 1 || done_idx[0] != 0 || err_idx.size() != 0 || acc_idx.size() != 1) begin
            bad++; $display("FAIL retry_done: done %p err %p acc %p want done '{0}", done_idx, err_idx, acc_idx);
        end
        clear_logs();
        m_nack_attempts = -1;
        post_one(0, 8'h33, 8'h44);
        wait_txn(1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL retry_fail_timeout: got %0d events want 1", err_idx.size()); end
        total++; if (start_cyc.size() !== 3) begin bad++; $display("FAIL retry_fail_starts: got %0d want 3", start_cyc.size()); end
        total++; if (err_idx.size() != 1 || err_idx[0] != 0 || done_idx.size() != 0) begin
            bad++; $display("FAIL retry_fail_err: err %p done %p want err '{0}", err_idx, done_idx);
        end
        m_nack_byte = -1; m_nack_attempts = 0;
    endtask
`endif

    task automatic test_eng_busy();
        bit ok;
        clear_logs();
        m_hold = 55;  // engine idle 56 cycles after stop, 40 past gap expiry
        post_one(1, 8'h3A, 8'h04);
        wait_txn(1, ok);
        total++; if (ok !== 1'b1 || done_idx.size() != 1 || done_idx[0] != 1) begin
            bad++; $display("FAIL busy_done: got %p want '{1}", done_idx);
        end
        total++;
        if ((done_cyc.size() > 0 && stop_cyc.size() > 0 ? done_cyc[0] - stop_cyc[0] : -1) !== 56) begin
            bad++; $display("FAIL busy_delay: got done %p stop %p want 56 apart", done_cyc, stop_cyc);
        end
        m_hold = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int exp_b[$];
        bit ok, mism;
        clear_logs();
        @(negedge clk);
        bus.req_addr = {8'h77, 8'h55};
        bus.req_data = {8'h88, 8'h66};
        bus.req_valid = 2'b01;
        for (int i = 0; i < 50 && bytes_q.size() < 2; i++) begin
            @(negedge clk);
            #2;
            if (acc_idx.size() > 0) bus.req_valid = 2'b00;
        end
        // Register address was just offered, so the FSM now sits in DATA.
        @(negedge clk);
        bus.req_valid = 2'b10;
        rst_n = 1'b0;
        #2;
        total++;
        if ({bus.req_ready, bus.done, bus.err, bus.busy, bus.eng_start, bus.eng_stop, bus.eng_wr_data} !== 17'd0) begin
            bad++; $display("FAIL midreset_outputs: got %h want 0",
                {bus.req_ready, bus.done, bus.err, bus.busy, bus.eng_start, bus.eng_stop, bus.eng_wr_data});
        end
        total++; if (bytes_q.size() !== 2) begin bad++; $display("FAIL midreset_prefix: got %p want 2 bytes", bytes_q); end
        repeat (3) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        #2;
        for (int i = 0; i < 20 && acc_idx.size() == 0; i++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        bus.req_valid = '0;
        wait_txn(1, ok);
        total++; if (ok !== 1'b1 || acc_idx.size() == 0 || acc_idx[0] != 1) begin
            bad++; $display("FAIL midreset_grant: got %p want first grant 1", acc_idx);
        end
        exp_b = {32'h42, 32'h77, 32'h88, STOP};
        mism = (bytes_q.size() != exp_b.size());
        if (!mism) for (int i = 0; i < exp_b.size(); i++) if (bytes_q[i] != exp_b[i]) mism = 1;
        total++; if (mism) begin bad++; $display("FAIL midreset_bytes: got %p want %p", bytes_q, exp_b); end
        total++; if (done_idx.size() != 1 || done_idx[0] != 1) begin
            bad++; $display("FAIL midreset_done: got %p want '{1}", done_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
`ifndef SCCB_ARB_RETRY_EN
        test_nack();
`else
        test_retry();
`endif
        test_eng_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/sccb_arbiter.md
# sccb_arbiter

Shares the single SCCB byte engine (`i2c_top`) between several requesters, each posting one-register write transactions `{reg_addr, reg_data}` to the OV7670.
- Grants round-robin.
- Sequences the engine byte-by-byte (device address, register address, register data, stop).
- Enforces an inter-transaction gap.
- Returns per-requester done/error pulses.

Sits between the camera power-up configuration sequencer, run-time tuning logic (gain, mirror, etc.) and the `i2c_top` instance.

## Interface
- `NREQ`, 2: number of requesters (1..8).
- `DEV_ADDR`, 8'h42: SCCB write slave address.
- `GAP_CYCLES`, 65536: minimum idle clocks after each stop.
- `MAX_RETRY`, 3: extra attempts on NACK (used only with `SCCB_ARB_RETRY_EN`).

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a pending transaction; held until accepted.
- `req_addr`  in  8*NREQ  register address, slice [8i+7:8i].
- `req_data`  in  8*NREQ  register data, same slicing.
- `req_ready`  out  NREQ  one-cycle accept pulse; operands are latched in this cycle.
- `done`  out  NREQ  one-cycle pulse: transaction completed with all ACKs.
- `err`  out  NREQ  one-cycle pulse: transaction abandoned on NACK.
- `busy`  out  1  high from accept through end of gap.
- `eng_start`  out  1  engine start strobe.
- `eng_stop`  out  1  engine stop strobe.
- `eng_wr_data`  out  8  byte offered to engine.
- `eng_ack`  in  2  [1] pulses at 9th bit, [0]=ACK.
- `eng_state`  in  4  engine state; 0 = idle.

## Operation
States:
- **IDLE**
  - If any `req_valid`, pick the lowest index strictly after `last_grant` (wrapping); `last_grant` resets to NREQ-1, so requester 0 wins first.
  - Pulse `req_ready[g]`, latch addr/data and g, set attempt=0 → START.
- **START**
  - `eng_start`=1, `eng_wr_data`=DEV_ADDR for one cycle → ADDR.
- **ADDR**
  - `eng_ack`==2'b11: `eng_wr_data`=latched addr → DATA.
  - `eng_ack`==2'b10: `eng_stop`=1, fail=1 → GAP.
- **DATA**
  - 2'b11: `eng_wr_data`=latched data → FIN.
  - 2'b10: stop, fail → GAP.
- **FIN**
  - Any ack tick: `eng_stop`=1; fail=~`eng_ack[0]` → GAP.
- **GAP**
  - Counter runs from 0. Exit when count ≥ GAP_CYCLES-1 and `eng_state`==0.
  - On exit: fail=0 → `done[g]`; fail=1 → `err[g]`. Update `last_grant`=g → IDLE.

Other rules:
- Engine strobes and `eng_wr_data` are combinational from state and `eng_ack`; they are 0 in every other state/cycle.
- `eng_ack` values other than 2'b11/2'b10 are ignored; the FSM waits indefinitely.
- `req_valid` may drop before grant; there is no penalty.
- A requester re-asserting in the cycle after done competes normally.
- Only one transaction is in flight; no queueing.

## Timing
- Reset: state=IDLE, `last_grant`=NREQ-1, counter=0. All outputs 0 (`req_ready`, `done`, `err`, `busy`, `eng_start`, `eng_stop`, `eng_wr_data`).
- Accept (IDLE) → `eng_start` exactly 1 cycle later.
- The next byte is presented in the same cycle as the ack tick.
- `done`/`err` fire GAP_CYCLES cycles after `eng_stop` at minimum, later if the engine is not yet idle.
- The next `req_ready` comes no earlier than the cycle after `done`/`err`.
- Reset mid-transaction: immediate return to reset values. The engine shares `rst_n`; no stop is emitted.

## Configuration
- `SCCB_ARB_RETRY_EN` defined:
  - On exit from GAP with fail=1 and attempt<MAX_RETRY: attempt++, clear fail, → START with the same g and operands.
  - No `err` and no re-arbitration during retries. `err` is raised only after MAX_RETRY+1 failed attempts.
- Undefined: the first NACK yields `err`; the attempt counter is not instantiated.

## Structure
- Package `sccb_pkg`:
  - State enum localparams (IDLE, START, ADDR, DATA, FIN, GAP).
  - ACK code constants `ACK_OK`=2'b11, `ACK_NACK`=2'b10.
  - OV7670 write address 8'h42.
- Sub-module `rr_arbiter` (NREQ-wide request vector + last-grant in, one-hot grant + index out, purely combinational). The FSM, latches and gap counter stay in `sccb_arbiter`.

## Test plan
- Single write, GAP_CYCLES=16, engine model always ACKs, req0 {0x12,0x80}:
  - `eng_start` with 0x42 one cycle after `req_ready[0]`.
  - Then bytes 0x12, 0x80, then stop.
  - `done[0]` ≥16 cycles after stop.
- Both requesters valid continuously:
  - Grants alternate 0,1,0,1.
  - No `req_ready` while `busy`.
- NACK on register-address byte, macro off:
  - `eng_stop` in the NACK cycle, `err[0]` after the gap.
  - No data byte sent.
- Macro on, MAX_RETRY=2, model NACKs the first 2 attempts:
  - Three start sequences with identical bytes, then `done` with no `err`.
  - Model NACKs always: `err` after the 3rd attempt.
- `eng_state` held nonzero 40 cycles past gap expiry: `done` delayed until `eng_state`==0.
- `rst_n` asserted during the DATA state: all outputs 0 immediately; after release, a pending req1 is granted first.
